msrv32_decoder: RTL and testbench

Instruction decoder for the msrv32 RV32I core, placed after instruction fetch. It takes the opcode, funct3 and funct7[5] fields, plus the low two bits of the immediate-adder result and the trap flag. It produces the control word for the ALU, immediate generator, load/store unit, CSR file, register file and write-back mux. All outputs are registered, giving one cycle of latency.

---
 rtl/msrv32_decoder_pkg.sv | 31 +++
 rtl/msrv32_decoder.sv | 152 +++++++++++++++
 tb/tb_msrv32_decoder.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/msrv32_decoder_pkg.sv
// rtl/msrv32_decoder_pkg.sv - shared msrv32 opcode-class, write-back and immediate-type constants
package msrv32_decoder_pkg;

   localparam logic [4:0] OPC_LOAD     = 5'b00000;
   localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
   localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
   localparam logic [4:0] OPC_AUIPC    = 5'b00101;
   localparam logic [4:0] OPC_STORE    = 5'b01000;
   localparam logic [4:0] OPC_OP       = 5'b01100;
   localparam logic [4:0] OPC_LUI      = 5'b01101;
   localparam logic [4:0] OPC_BRANCH   = 5'b11000;
   localparam logic [4:0] OPC_JALR     = 5'b11001;
   localparam logic [4:0] OPC_JAL      = 5'b11011;
   localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

   localparam logic [2:0] WB_ALU     = 3'b000;
   localparam logic [2:0] WB_LU      = 3'b001;
   localparam logic [2:0] WB_IMM     = 3'b010;
   localparam logic [2:0] WB_IADDER  = 3'b011;
   localparam logic [2:0] WB_CSR     = 3'b100;
   localparam logic [2:0] WB_PC_PLUS = 3'b101;

   localparam logic [2:0] IMM_R   = 3'b000;
   localparam logic [2:0] IMM_I   = 3'b001;
   localparam logic [2:0] IMM_S   = 3'b010;
   localparam logic [2:0] IMM_B   = 3'b011;
   localparam logic [2:0] IMM_U   = 3'b100;
   localparam logic [2:0] IMM_J   = 3'b101;
   localparam logic [2:0] IMM_CSR = 3'b110;

endpackage

// File: rtl/msrv32_decoder.sv
// rtl/msrv32_decoder.sv - RV32I instruction decoder with a single registered output stage
module msrv32_decoder
   import msrv32_decoder_pkg::*;
(
   input  logic       ms_riscv32_mp_clk_in,
   input  logic       ms_riscv32_mp_rst_n_in,
   input  logic       trap_taken_in,
   input  logic       funct7_5_in,
   input  logic [6:0] opcode_in,
   input  logic [2:0] funct3_in,
   input  logic [1:0] iadder_out_1_to_0_in,
   output logic [2:0] wb_mux_sel_out,
   output logic [2:0] imm_type_out,
   output logic [2:0] csr_op_out,
   output logic       mem_wr_req_out,
   output logic [3:0] alu_opcode_out,
   output logic [1:0] load_size_out,
   output logic       load_unsigned_out,
   output logic       alu_src_out,
   output logic       iadder_src_out,
   output logic       csr_wr_en_out,
   output logic       rf_wr_en_out,
   output logic       illegal_instr_out,
   output logic       misaligned_load_out,
   output logic       misaligned_store_out
);

   logic [4:0] w_opc;
   logic       w_is_load, w_is_misc_mem, w_is_op_imm, w_is_auipc, w_is_store;
   logic       w_is_op, w_is_lui, w_is_branch, w_is_jalr, w_is_jal, w_is_system;
   logic       w_is_csr, w_implemented, w_illegal;
   logic       w_mis_word, w_mis_half, w_mis_load, w_mis_store;
   logic       w_alu_alt, w_rf_wr_en, w_mem_wr_req, w_iadder_src;
   logic [2:0] w_wb_sel, w_imm_type;

   assign w_opc         = opcode_in[6:2];
   assign w_is_load     = (w_opc == OPC_LOAD);
   assign w_is_misc_mem = (w_opc == OPC_MISC_MEM);
   assign w_is_op_imm   = (w_opc == OPC_OP_IMM);
   assign w_is_auipc    = (w_opc == OPC_AUIPC);
   assign w_is_store    = (w_opc == OPC_STORE);
   assign w_is_op       = (w_opc == OPC_OP);
   assign w_is_lui      = (w_opc == OPC_LUI);
   assign w_is_branch   = (w_opc == OPC_BRANCH);
   assign w_is_jalr     = (w_opc == OPC_JALR);
   assign w_is_jal      = (w_opc == OPC_JAL);
   assign w_is_system   = (w_opc == OPC_SYSTEM);
   assign w_is_csr      = w_is_system & (funct3_in != 3'b000);

   always_comb begin
      w_implemented = 1'b0;
      case (w_opc)
         OPC_LOAD:   w_implemented = (funct3_in != 3'b011) && (funct3_in != 3'b110) && (funct3_in != 3'b111);
         OPC_STORE:  w_implemented = (funct3_in[2] == 1'b0) && (funct3_in[1:0] != 2'b11);
         OPC_BRANCH: w_implemented = (funct3_in[2:1] != 2'b01);
         OPC_JALR:   w_implemented = (funct3_in == 3'b000);
         OPC_SYSTEM: w_implemented = (funct3_in != 3'b100);
         OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_MISC_MEM:
                     w_implemented = 1'b1;
         default:    w_implemented = 1'b0;
      endcase
   end

   assign w_illegal = ~opcode_in[0] | ~opcode_in[1] | ~w_implemented;

   // Same alignment rule covers loads and stores; byte accesses never misalign.
   assign w_mis_word   = (funct3_in[1:0] == 2'b10) & (iadder_out_1_to_0_in[1] | iadder_out_1_to_0_in[0]);
   assign w_mis_half   = (funct3_in[1:0] == 2'b01) & iadder_out_1_to_0_in[0];
   assign w_mis_load   = w_is_load  & (w_mis_word | w_mis_half);
   assign w_mis_store  = w_is_store & (w_mis_word | w_mis_half);
   assign w_mem_wr_req = w_is_store & ~w_mis_store & ~trap_taken_in;

   assign w_alu_alt    = funct7_5_in & (w_is_op | (w_is_op_imm & (funct3_in == 3'b101)));
   assign w_iadder_src = w_is_load | w_is_store | w_is_jalr;
   assign w_rf_wr_en   = w_is_lui | w_is_auipc | w_is_jal | w_is_jalr | w_is_op |
                         w_is_op_imm | w_is_load | w_is_csr;

   always_comb begin
      w_imm_type = IMM_R;
      w_wb_sel   = WB_ALU;
      case (w_opc)
         OPC_OP_IMM: w_imm_type = IMM_I;
         OPC_LOAD: begin
            w_imm_type = IMM_I;
            w_wb_sel   = WB_LU;
         end
         OPC_JALR: begin
            w_imm_type = IMM_I;
            w_wb_sel   = WB_PC_PLUS;
         end
         OPC_STORE:  w_imm_type = IMM_S;
         OPC_BRANCH: w_imm_type = IMM_B;
         OPC_LUI: begin
            w_imm_type = IMM_U;
            w_wb_sel   = WB_IMM;
         end
         OPC_AUIPC: begin
            w_imm_type = IMM_U;
            w_wb_sel   = WB_IADDER;
         end
         OPC_JAL: begin
            w_imm_type = IMM_J;
            w_wb_sel   = WB_PC_PLUS;
         end
         OPC_SYSTEM: begin
            if (w_is_csr) begin
               w_imm_type = IMM_CSR;
               w_wb_sel   = WB_CSR;
            end
         end
         default: begin
            w_imm_type = IMM_R;
            w_wb_sel   = WB_ALU;
         end
      endcase
   end

   always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
      if (!ms_riscv32_mp_rst_n_in) begin
         wb_mux_sel_out       <= 3'b000;
         imm_type_out         <= 3'b000;
         csr_op_out           <= 3'b000;
         mem_wr_req_out       <= 1'b0;
         alu_opcode_out       <= 4'b0000;
         load_size_out        <= 2'b00;
         load_unsigned_out    <= 1'b0;
         alu_src_out          <= 1'b0;
         iadder_src_out       <= 1'b0;
         csr_wr_en_out        <= 1'b0;
         rf_wr_en_out         <= 1'b0;
         illegal_instr_out    <= 1'b0;
         misaligned_load_out  <= 1'b0;
         misaligned_store_out <= 1'b0;
      end else begin
         wb_mux_sel_out       <= w_wb_sel;
         imm_type_out         <= w_imm_type;
         csr_op_out           <= funct3_in;
         mem_wr_req_out       <= w_mem_wr_req;
         alu_opcode_out       <= {w_alu_alt, funct3_in};
         load_size_out        <= funct3_in[1:0];
         load_unsigned_out    <= funct3_in[2];
         alu_src_out          <= opcode_in[5];
         iadder_src_out       <= w_iadder_src;
         csr_wr_en_out        <= w_is_csr;
         rf_wr_en_out         <= w_rf_wr_en;
         illegal_instr_out    <= w_illegal;
         misaligned_load_out  <= w_mis_load;
         misaligned_store_out <= w_mis_store;
      end
   end

endmodule

// File: tb/tb_msrv32_decoder.sv
// tb/tb_msrv32_decoder.sv - scoreboard bench for msrv32_decoder
module tb_msrv32_decoder;

   logic       clk;
   logic       rst_n;
   logic       trap;
   logic       f75;
   logic [6:0] opcode;
   logic [2:0] f3;
   logic [1:0] ia;
   logic [2:0] wb_sel, imm_type, csr_op;
   logic       mem_wr;
   logic [3:0] alu_op;
   logic [1:0] ld_size;
   logic       ld_uns, alu_src, ia_src, csr_wr, rf_wr, ill, mis_ld, mis_st;

   int tests = 0;
   int fails = 0;

   typedef struct {
      string       name;
      logic [23:0] exp;
   } sb_t;
   sb_t sbq[$];

   msrv32_decoder dut (
      .ms_riscv32_mp_clk_in   (clk),
      .ms_riscv32_mp_rst_n_in (rst_n),
      .trap_taken_in          (trap),
      .funct7_5_in            (f75),
      .opcode_in              (opcode),
      .funct3_in              (f3),
      .iadder_out_1_to_0_in   (ia),
      .wb_mux_sel_out         (wb_sel),
      .imm_type_out           (imm_type),
      .csr_op_out             (csr_op),
      .mem_wr_req_out         (mem_wr),
      .alu_opcode_out         (alu_op),
      .load_size_out          (ld_size),
      .load_unsigned_out      (ld_uns),
      .alu_src_out            (alu_src),
      .iadder_src_out         (ia_src),
      .csr_wr_en_out          (csr_wr),
      .rf_wr_en_out           (rf_wr),
      .illegal_instr_out      (ill),
      .misaligned_load_out    (mis_ld),
      .misaligned_store_out   (mis_st)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [23:0] actual();
      return {wb_sel, imm_type, csr_op, mem_wr, alu_op, ld_size, ld_uns,
              alu_src, ia_src, csr_wr, rf_wr, ill, mis_ld, mis_st};
   endfunction

   // Field order: wb imm csr_op mem_wr alu_op ld_size ld_uns alu_src ia_src csr_wr rf_wr ill mis_ld mis_st
   function automatic logic [23:0] ctl(input logic [2:0] w, input logic [2:0] im,
                                       input logic [2:0] co, input logic mw,
                                       input logic [3:0] ao, input logic [1:0] ls,
                                       input logic lu, input logic as, input logic is,
                                       input logic cw, input logic rw, input logic il,
                                       input logic ml, input logic ms);
      return {w, im, co, mw, ao, ls, lu, as, is, cw, rw, il, ml, ms};
   endfunction

   task automatic issue(input string name, input logic t, input logic s7,
                        input logic [6:0] op, input logic [2:0] fn3,
                        input logic [1:0] a, input logic [23:0] exp);
      sb_t e;
      @(posedge clk);
      #2;
      trap = t; f75 = s7; opcode = op; f3 = fn3; ia = a;
      e.name = name;
      e.exp  = exp;
      sbq.push_back(e);
   endtask

   task automatic drain();
      int n = 0;
      while (sbq.size() > 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (sbq.size() != 0) begin
         fails++;
         $display("FAIL drain_timeout: %0d entries left, required 0", sbq.size());
         sbq.delete();
      end
   endtask

   // Monitor: one decoded word is presented per rising edge.
   initial begin
      sb_t e;
      forever begin
         @(posedge clk);
         #1;
         if (rst_n && sbq.size() > 0) begin
            e = sbq.pop_front();
            tests++;
            if (actual() !== e.exp) begin
               fails++;
               $display("FAIL %s: got %06h required %06h", e.name, actual(), e.exp);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; trap = 1'b0; f75 = 1'b0; opcode = 7'h00; f3 = 3'b000; ia = 2'b00;
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if (actual() !== 24'h0) begin
         fails++;
         $display("FAIL reset_state: got %06h required 000000", actual());
      end
      @(negedge clk);
      rst_n = 1'b1;

      issue("op_add",   0, 0, 7'b0110011, 3'b000, 2'b00, ctl(3'b000,3'b000,3'b000,0,4'b0000,2'b00,0,1,0,0,1,0,0,0));
      issue("op_sub",   0, 1, 7'b0110011, 3'b000, 2'b00, ctl(3'b000,3'b000,3'b000,0,4'b1000,2'b00,0,1,0,0,1,0,0,0));
      issue("slti",     0, 0, 7'b0010011, 3'b010, 2'b01, ctl(3'b000,3'b001,3'b010,0,4'b0010,2'b10,0,0,0,0,1,0,0,0));
      issue("srai",     0, 1, 7'b0010011, 3'b101, 2'b00, ctl(3'b000,3'b001,3'b101,0,4'b1101,2'b01,1,0,0,0,1,0,0,0));
      issue("addi_f7",  0, 1, 7'b0010011, 3'b000, 2'b00, ctl(3'b000,3'b001,3'b000,0,4'b0000,2'b00,0,0,0,0,1,0,0,0));
      issue("load_f3_3",0, 0, 7'b0000011, 3'b011, 2'b00, ctl(3'b001,3'b001,3'b011,0,4'b0011,2'b11,0,0,1,0,1,1,0,0));
      issue("lw_mis",   0, 0, 7'b0000011, 3'b010, 2'b10, ctl(3'b001,3'b001,3'b010,0,4'b0010,2'b10,0,0,1,0,1,0,1,0));
      issue("lhu_mis",  0, 0, 7'b0000011, 3'b101, 2'b01, ctl(3'b001,3'b001,3'b101,0,4'b0101,2'b01,1,0,1,0,1,0,1,0));
      issue("jalr_f3_2",0, 0, 7'b1100111, 3'b010, 2'b00, ctl(3'b101,3'b001,3'b010,0,4'b0010,2'b10,0,1,1,0,1,1,0,0));
      issue("sw_mis",   0, 0, 7'b0100011, 3'b010, 2'b01, ctl(3'b000,3'b010,3'b010,0,4'b0010,2'b10,0,1,1,0,0,0,0,1));
      issue("sw_ok",    0, 0, 7'b0100011, 3'b010, 2'b00, ctl(3'b000,3'b010,3'b010,1,4'b0010,2'b10,0,1,1,0,0,0,0,0));
      issue("sw_trap",  1, 0, 7'b0100011, 3'b010, 2'b00, ctl(3'b000,3'b010,3'b010,0,4'b0010,2'b10,0,1,1,0,0,0,0,0));
      issue("jal",      0, 0, 7'b1101111, 3'b000, 2'b00, ctl(3'b101,3'b101,3'b000,0,4'b0000,2'b00,0,1,0,0,1,0,0,0));
      issue("lui_trap", 1, 0, 7'b0110111, 3'b000, 2'b00, ctl(3'b010,3'b100,3'b000,0,4'b0000,2'b00,0,1,0,0,1,0,0,0));
      issue("auipc",    0, 0, 7'b0010111, 3'b000, 2'b00, ctl(3'b011,3'b100,3'b000,0,4'b0000,2'b00,0,0,0,0,1,0,0,0));
      issue("csrrw",    0, 0, 7'b1110011, 3'b001, 2'b00, ctl(3'b100,3'b110,3'b001,0,4'b0001,2'b01,0,1,0,1,1,0,0,0));
      issue("ecall",    0, 0, 7'b1110011, 3'b000, 2'b00, ctl(3'b000,3'b000,3'b000,0,4'b0000,2'b00,0,1,0,0,0,0,0,0));
      issue("sys_f3_4", 0, 0, 7'b1110011, 3'b100, 2'b00, ctl(3'b100,3'b110,3'b100,0,4'b0100,2'b00,1,1,0,1,1,1,0,0));
      issue("beq",      0, 0, 7'b1100011, 3'b000, 2'b00, ctl(3'b000,3'b011,3'b000,0,4'b0000,2'b00,0,1,0,0,0,0,0,0));
      issue("br_f3_2",  0, 0, 7'b1100011, 3'b010, 2'b00, ctl(3'b000,3'b011,3'b010,0,4'b0010,2'b10,0,1,0,0,0,1,0,0));
      issue("fence",    0, 0, 7'b0001111, 3'b000, 2'b00, ctl(3'b000,3'b000,3'b000,0,4'b0000,2'b00,0,0,0,0,0,0,0,0));
      issue("op_low01", 0, 0, 7'b0110001, 3'b000, 2'b00, ctl(3'b000,3'b000,3'b000,0,4'b0000,2'b00,0,1,0,0,1,1,0,0));
      issue("bad_class",0, 0, 7'b1111111, 3'b000, 2'b00, ctl(3'b000,3'b000,3'b000,0,4'b0000,2'b00,0,1,0,0,0,1,0,0));
      issue("sb_odd",   0, 0, 7'b0100011, 3'b000, 2'b11, ctl(3'b000,3'b010,3'b000,1,4'b0000,2'b00,0,1,1,0,0,0,0,0));
      issue("sh_mis",   0, 0, 7'b0100011, 3'b001, 2'b01, ctl(3'b000,3'b010,3'b001,0,4'b0001,2'b01,0,1,1,0,0,0,0,1));
      issue("jal_pre",  0, 0, 7'b1101111, 3'b000, 2'b00, ctl(3'b101,3'b101,3'b000,0,4'b0000,2'b00,0,1,0,0,1,0,0,0));
      drain();

      // Asynchronous reset away from any clock edge.
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      tests++;
      if (actual() !== 24'h0) begin
         fails++;
         $display("FAIL async_reset: got %06h required 000000", actual());
      end
      @(negedge clk);
      rst_n = 1'b1;
      issue("post_reset_csrrs", 0, 0, 7'b1110011, 3'b010, 2'b00, ctl(3'b100,3'b110,3'b010,0,4'b0010,2'b10,0,1,0,1,1,0,0,0));
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
